// File: rtl/cordic_comp.sv
`default_nettype none
// ============================================================================
// Module   : cordic_comp
// Purpose  : Iterative rotation-mode CORDIC. One micro-rotation per clock
//            drives z toward zero while rotating (x, y), producing cos/sin
//            of the initial angle when x starts at the CORDIC gain K.
// Ports    : x_initial_in, y_initial_in, z_initial_in - start values, signed
//            Q0.(BIT_WIDTH-1), loaded only on edges where rst is high
//            rst   - synchronous active-high reload/restart
//            clk   - rising-edge clock
//            x_out, y_out, z_out - current x/y/z registers (cos, sin,
//            residual angle once the run completes)
// Revision : 1.0 - initial release
// ============================================================================
module cordic_comp #(
  parameter int BIT_WIDTH = 8
) (
  input  logic [BIT_WIDTH-1:0] x_initial_in,
  input  logic [BIT_WIDTH-1:0] y_initial_in,
  input  logic [BIT_WIDTH-1:0] z_initial_in,
  input  logic                 rst,
  input  logic                 clk,
  output logic [BIT_WIDTH-1:0] x_out,
  output logic [BIT_WIDTH-1:0] y_out,
  output logic [BIT_WIDTH-1:0] z_out
);

  // Counter is 4 bits: enough for BIT_WIDTH-1 = 15 at the widest setting.
  localparam int            IW     = 4;
  localparam logic [IW-1:0] C_LAST = IW'(BIT_WIDTH - 1);

  logic signed [BIT_WIDTH-1:0] x_q, x_d;
  logic signed [BIT_WIDTH-1:0] y_q, y_d;
  logic signed [BIT_WIDTH-1:0] z_q, z_d;
  logic        [IW-1:0]        i_q, i_d;

  logic        [31:0]          atan_raw;
  logic signed [BIT_WIDTH-1:0] atan_w;
  logic signed [BIT_WIDTH-1:0] x_sh;
  logic signed [BIT_WIDTH-1:0] y_sh;

  // atan(2^-i) scaled by 2^30; rescaled with round-half-up to the data width.
  always_comb begin
    case (i_q)
      4'd0:    atan_raw = 32'h3243_F6A8;
      4'd1:    atan_raw = 32'h1DAC_6705;
      4'd2:    atan_raw = 32'h0FAD_BAFC;
      4'd3:    atan_raw = 32'h07F5_6EA6;
      4'd4:    atan_raw = 32'h03FE_AB76;
      4'd5:    atan_raw = 32'h01FF_D55B;
      4'd6:    atan_raw = 32'h00FF_FAAA;
      4'd7:    atan_raw = 32'h007F_FF55;
      4'd8:    atan_raw = 32'h003F_FFEA;
      4'd9:    atan_raw = 32'h001F_FFFD;
      4'd10:   atan_raw = 32'h000F_FFFF;
      4'd11:   atan_raw = 32'h0007_FFFF;
      4'd12:   atan_raw = 32'h0003_FFFF;
      4'd13:   atan_raw = 32'h0001_FFFF;
      4'd14:   atan_raw = 32'h0000_FFFF;
      default: atan_raw = 32'h0000_7FFF;
    endcase
  end

  assign atan_w = BIT_WIDTH'((atan_raw + (32'd1 << (30 - BIT_WIDTH))) >> (31 - BIT_WIDTH));

  // Arithmetic shifts of the pre-update values (floor toward -inf).
  assign x_sh = x_q >>> i_q;
  assign y_sh = y_q >>> i_q;

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    z_d = z_q;
    i_d = i_q;
    if (i_q < C_LAST) begin
      // z == 0 takes the positive branch.
      if (!z_q[BIT_WIDTH-1]) begin
        x_d = x_q - y_sh;
        y_d = y_q + x_sh;
        z_d = z_q - atan_w;
      end else begin
        x_d = x_q + y_sh;
        y_d = y_q - x_sh;
        z_d = z_q + atan_w;
      end
      i_d = i_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x_q <= x_initial_in;
      y_q <= y_initial_in;
      z_q <= z_initial_in;
      i_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
      z_q <= z_d;
      i_q <= i_d;
    end
  end

  assign x_out = x_q;
  assign y_out = y_q;
  assign z_out = z_q;

endmodule
`default_nettype wire

// File: tb/tb_cordic_comp.sv
`default_nettype none
// ============================================================================
// Module   : tb_cordic_comp
// Purpose  : Self-checking bench for cordic_comp (BIT_WIDTH = 8). A behavioural
//            model predicts x/y/z after every edge; predictions are queued when
//            stimulus is driven and compared after the edge. Known-answer
//            points (30 deg, -30 deg, hold, mid-run reset) are also checked
//            against fixed constants.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cordic_comp;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] x_in, y_in, z_in;
  logic [W-1:0] x_out, y_out, z_out;

  typedef struct packed {
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic [W-1:0] z;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // Behavioural model state
  int m_x, m_y, m_z, m_i;
  int atan_tab[16];

  cordic_comp #(.BIT_WIDTH(W)) dut (
    .x_initial_in(x_in),
    .y_initial_in(y_in),
    .z_initial_in(z_in),
    .rst         (rst),
    .clk         (clk),
    .x_out       (x_out),
    .y_out       (y_out),
    .z_out       (z_out)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got 0x%h expected 0x%h", tag, obs, exp_v);
    end
  endtask

  function automatic int wrap(input int v);
    logic signed [W-1:0] t;
    t = v[W-1:0];
    return int'(t);
  endfunction

  function automatic int sx(input logic [W-1:0] v);
    logic signed [W-1:0] t;
    t = v;
    return int'(t);
  endfunction

  // Advance the model by one edge using the inputs currently driven.
  task automatic model_edge();
    int nx, ny, nz, sh_x, sh_y;
    if (rst) begin
      m_x = sx(x_in); m_y = sx(y_in); m_z = sx(z_in); m_i = 0;
    end else if (m_i < W - 1) begin
      // floor division by 2^i
      sh_x = $rtoi($floor(real'(m_x) / (2.0 ** m_i)));
      sh_y = $rtoi($floor(real'(m_y) / (2.0 ** m_i)));
      if (m_z >= 0) begin
        nx = m_x - sh_y; ny = m_y + sh_x; nz = m_z - atan_tab[m_i];
      end else begin
        nx = m_x + sh_y; ny = m_y - sh_x; nz = m_z + atan_tab[m_i];
      end
      m_x = wrap(nx); m_y = wrap(ny); m_z = wrap(nz); m_i++;
    end
  endtask

  // Drive one cycle of stimulus, queue the prediction, compare after the edge.
  task automatic step(input logic r, input logic [W-1:0] xi, input logic [W-1:0] yi,
                      input logic [W-1:0] zi);
    exp_t e;
    @(negedge clk);
    rst = r; x_in = xi; y_in = yi; z_in = zi;
    model_edge();
    e.x = m_x[W-1:0]; e.y = m_y[W-1:0]; e.z = m_z[W-1:0];
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check_val("sb_empty", 8'h00, 8'hFF);
    end else begin
      e = sb.pop_front();
      check_val("sb_x", x_out, e.x);
      check_val("sb_y", y_out, e.y);
      check_val("sb_z", z_out, e.z);
    end
  endtask

  task automatic run_idle(input int n);
    for (int k = 0; k < n; k++)
      step(1'b0, W'($urandom), W'($urandom), W'($urandom));
  endtask

  task automatic check_xyz(input string tag, input logic [W-1:0] ex,
                           input logic [W-1:0] ey, input logic [W-1:0] ez);
    check_val({tag, "_x"}, x_out, ex);
    check_val({tag, "_y"}, y_out, ey);
    check_val({tag, "_z"}, z_out, ez);
  endtask

  initial begin
    for (int k = 0; k < 16; k++)
      atan_tab[k] = $rtoi($floor($atan(2.0 ** (-k)) * (2.0 ** (W - 1)) + 0.5));
    rst = 1'b1; x_in = '0; y_in = '0; z_in = '0;
    m_x = 0; m_y = 0; m_z = 0; m_i = 0;

    // Known-answer: 30 degrees
    step(1'b1, 8'h4D, 8'h00, 8'h43);
    check_xyz("reset", 8'h4D, 8'h00, 8'h43);
    step(1'b0, 8'h4D, 8'h00, 8'h43);
    check_xyz("iter0", 8'h4D, 8'h4D, 8'hDE);
    for (int k = 0; k < 6; k++) step(1'b0, 8'h4D, 8'h00, 8'h43);
    check_xyz("cos30", 8'h6F, 8'h3F, 8'h00);

    // Hold after completion; input changes ignored
    run_idle(5);
    check_xyz("hold", 8'h6F, 8'h3F, 8'h00);

    // -30 degrees
    step(1'b1, 8'h4D, 8'h00, 8'hBD);
    for (int k = 0; k < 7; k++) step(1'b0, 8'h4D, 8'h00, 8'hBD);
    check_xyz("neg30", 8'h6F, 8'hC0, 8'h00);

    // Mid-run reset after 3 iterations
    step(1'b1, 8'h4D, 8'h00, 8'h43);
    for (int k = 0; k < 3; k++) step(1'b0, 8'h4D, 8'h00, 8'h43);
    step(1'b1, 8'h4D, 8'h00, 8'hBD);
    check_xyz("abort", 8'h4D, 8'h00, 8'hBD);
    for (int k = 0; k < 7; k++) step(1'b0, 8'h4D, 8'h00, 8'hBD);
    check_xyz("restart", 8'h6F, 8'hC0, 8'h00);

    // Random runs within the valid range, random inputs while running,
    // occasional early reset, and wrapping cases with large x/y.
    for (int r = 0; r < 24; r++) begin
      int lim, len;
      lim = (r % 4 == 3) ? 127 : 77;
      step(1'b1, W'($urandom_range(2 * lim) - lim), W'($urandom_range(2 * lim) - lim),
           W'($urandom_range(222) - 111));
      len = (r % 5 == 4) ? $urandom_range(1, 5) : $urandom_range(7, 10);
      run_idle(len);
    end

    // Zero angle boundary: z = 0 takes the positive branch
    step(1'b1, 8'h4D, 8'h00, 8'h00);
    run_idle(7);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
